imem_write_arbiter: RTL and testbench
=====================================

# imem_write_arbiter

Shares the single IMEM write port between CPU stores (already steered and masked for IMEM by the store path) and the UART program loader. CPU stores are absorbed into a small FIFO so the pipeline rarely stalls. The loader has priority, bounded by a starvation limit. All IMEM write outputs are registered, and a drained flag lets the core implement `fence.i`.

## Interface
- AWIDTH, 14, IMEM word-address width
- DWIDTH, 32, write-data width
- DEPTH, 4, CPU store FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, maximum consecutive loader grants while the CPU FIFO is non-empty
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- cpu_valid  in  1  CPU store request
- cpu_ready  out  1  CPU store accepted when `cpu_valid & cpu_ready`
- cpu_addr  in  AWIDTH  store word address
- cpu_data  in  DWIDTH  store data, already lane-shifted
- cpu_wea  in  4  byte mask
- ldr_valid  in  1  loader write request
- ldr_ready  out  1  loader grant; write accepted when `ldr_valid & ldr_ready`
- ldr_addr  in  AWIDTH  loader word address
- ldr_data  in  DWIDTH  loader data
- ldr_wea  in  4  loader byte mask
- imem_addr  out  AWIDTH  registered IMEM address
- imem_din  out  DWIDTH  registered IMEM data
- imem_wea  out  4  registered IMEM byte enables
- pending  out  $clog2(DEPTH)+1  CPU FIFO occupancy
- drained  out  1  high when the FIFO is empty and `imem_wea` is 4'b0000

## Operation
- **CPU path**
  - `cpu_ready = ~full & ~rst`; there is no pass-through when full, even if the FIFO pops in the same cycle.
  - An accepted store with `cpu_wea == 0` is consumed but not enqueued.
  - Otherwise {addr, data, wea} is pushed at the edge.
- **Arbitration** (combinational, evaluated every cycle; at most one grant per cycle)
  - `ldr_ready = ~rst & ~force_cpu`
  - `cpu_grant = ~empty & (force_cpu | ~ldr_valid)`
  - `force_cpu = ~empty & (full | wait_cnt == STARVE_LIMIT)`
- **Starvation counter (`wait_cnt`)**
  - Increments on each loader acceptance while the FIFO is non-empty.
  - Clears on every CPU grant and whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- **Issue**
  - The granted request is registered into `imem_addr`/`imem_din`/`imem_wea`.
  - A CPU grant pops the FIFO head at the same edge.
  - With no grant, `imem_wea` is 4'b0000; `imem_addr`/`imem_din` hold their last value.
- **Push and pop together**: occupancy is unchanged and `pending` stays constant.
- **FIFO**: read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `full`/`empty` are derived from the count, not from pointer equality alone.
- **Ordering**: CPU stores issue in acceptance order. Loader and CPU writes to the same address resolve by issue order; the loader is responsible for not overlapping CPU traffic.

## Timing
- **Reset values**: `imem_wea`=0, `imem_addr`=0, `imem_din`=0, `pending`=0, `drained`=1, `cpu_ready`=0, `ldr_ready`=0, `wait_cnt`=0, pointers=0.
- **Reset mid-operation**
  - FIFO contents are discarded.
  - A write already in the output register is cleared at the reset edge and is not retried.
- **CPU latency**: a store accepted at edge E0 with an idle loader is granted in the cycle after E0. It appears on `imem_*` after edge E1 and is written by IMEM at E2. That is one cycle of FIFO latency plus one register stage.
- **Loader latency**: a request accepted at edge E0 appears on `imem_*` after E0.
- **Throughput**: one IMEM write per cycle sustained.
- **`drained`**: rises in the cycle after the last write leaves the output register.

## Test plan
- **Reset**: hold rst for 2 cycles with `cpu_valid`=`ldr_valid`=1 -> no handshakes; `imem_wea`=0, `drained`=1, `pending`=0.
- **CPU only**: 3 back-to-back stores to addr 0x10/0x11/0x12, data 0xA/0xB/0xC, wea 4'hF.
  - `imem_wea`=F with the same addresses and data, in order, starting 2 cycles after the first acceptance.
  - `drained`=1 after the third write.
- **Full FIFO**: loader continuously valid, 5 CPU stores issued.
  - `cpu_ready` drops once `pending`=4.
  - While the FIFO is full, `force_cpu` holds `ldr_ready` low and the FIFO drains one entry per cycle.
  - No store is lost or reordered.
- **Starvation**: 1 CPU store queued, loader valid every cycle -> exactly 8 loader writes, then 1 CPU write, then loader writes resume.
- **Zero mask**: store with `cpu_wea`=0 -> accepted, `pending` stays 0, no IMEM write.
- **Simultaneous push/pop at `pending`=2**: `pending` stays 2, pointers wrap correctly past DEPTH-1, and data order is preserved.

Source files
------------

// File: rtl/imem_write_arbiter.sv
// rtl/imem_write_arbiter.sv - arbitrates the IMEM write port between a CPU store FIFO and the UART loader
module imem_write_arbiter #(
  parameter int AWIDTH       = 14,
  parameter int DWIDTH       = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_valid,
  output logic                     cpu_ready,
  input  logic [AWIDTH-1:0]        cpu_addr,
  input  logic [DWIDTH-1:0]        cpu_data,
  input  logic [3:0]               cpu_wea,
  input  logic                     ldr_valid,
  output logic                     ldr_ready,
  input  logic [AWIDTH-1:0]        ldr_addr,
  input  logic [DWIDTH-1:0]        ldr_data,
  input  logic [3:0]               ldr_wea,
  output logic [AWIDTH-1:0]        imem_addr,
  output logic [DWIDTH-1:0]        imem_din,
  output logic [3:0]               imem_wea,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [AWIDTH-1:0] fifo_addr [DEPTH];
  logic [DWIDTH-1:0] fifo_data [DEPTH];
  logic [3:0]        fifo_wea  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;

  logic full;
  logic empty;
  logic force_cpu;
  logic cpu_grant;
  logic ldr_accept;
  logic push;
  logic pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign cpu_ready  = ~full & ~rst;
  assign force_cpu  = ~empty & (full | (wait_cnt == WW'(STARVE_LIMIT)));
  assign ldr_ready  = ~rst & ~force_cpu;
  assign cpu_grant  = ~empty & (force_cpu | ~ldr_valid);
  assign ldr_accept = ldr_valid & ldr_ready;

  // Zero-mask stores are handshaken but never occupy a FIFO slot.
  assign push = cpu_valid & cpu_ready & (cpu_wea != 4'b0000);
  assign pop  = cpu_grant;

  assign pending = count;
  assign drained = empty & (imem_wea == 4'b0000);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_data;
      fifo_wea[wr_ptr]  <= cpu_wea;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cpu_grant || empty)
        wait_cnt <= '0;
      else if (ldr_accept && wait_cnt != WW'(STARVE_LIMIT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Loader and CPU grants are mutually exclusive, so the priority order here is arbitrary.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr <= '0;
      imem_din  <= '0;
      imem_wea  <= 4'b0000;
    end else if (ldr_accept) begin
      imem_addr <= ldr_addr;
      imem_din  <= ldr_data;
      imem_wea  <= ldr_wea;
    end else if (cpu_grant) begin
      imem_addr <= fifo_addr[rd_ptr];
      imem_din  <= fifo_data[rd_ptr];
      imem_wea  <= fifo_wea[rd_ptr];
    end else begin
      imem_wea  <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_imem_write_arbiter.sv
// tb/tb_imem_write_arbiter.sv - randomized and directed bench for imem_write_arbiter against a queue model
module tb_imem_write_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic [3:0]    cpu_wea;
  logic          ldr_valid, ldr_ready;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_data;
  logic [3:0]    ldr_wea;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_din;
  logic [3:0]    imem_wea;
  logic [2:0]    pending;
  logic          drained;

  imem_write_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wea(cpu_wea),
    .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_wea(ldr_wea),
    .imem_addr(imem_addr), .imem_din(imem_din), .imem_wea(imem_wea),
    .pending(pending), .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    wea;
  } wr_t;

  wr_t           m_q[$];
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [3:0]    m_wea;
  logic          m_cpu_acc;

  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  logic [3:0]    log_wea[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_wea.delete();
  endtask

  // One clock: drive inputs, check handshakes against the model, advance the model, check the write port.
  task automatic step(input logic r, input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic [3:0] cw, input logic lv, input logic [AW-1:0] la,
                      input logic [DW-1:0] ld, input logic [3:0] lw);
    int  n;
    bit  is_full, force_c, rdy_c, rdy_l, ldr_wins;
    rst = r; cpu_valid = cv; cpu_addr = ca; cpu_data = cd; cpu_wea = cw;
    ldr_valid = lv; ldr_addr = la; ldr_data = ld; ldr_wea = lw;
    #1;
    n       = m_q.size();
    is_full = (n == DEPTH);
    force_c = (n > 0) && (is_full || m_wait == LIMIT);
    rdy_c   = !r && !is_full;
    rdy_l   = !r && !force_c;
    check("cpu_ready", cpu_ready, rdy_c);
    check("ldr_ready", ldr_ready, rdy_l);
    check("pending", pending, n);
    check("drained", drained, (n == 0) && (m_wea == 4'b0));
    m_cpu_acc = cv && rdy_c;
    if (r) begin
      m_q.delete();
      m_wait = 0;
      m_addr = '0; m_din = '0; m_wea = '0;
    end else begin
      ldr_wins = lv && !force_c;
      if (ldr_wins) begin
        m_addr = la; m_din = ld; m_wea = lw;
        m_wait = (n == 0) ? 0 : ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1);
      end else if (n > 0) begin
        m_addr = m_q[0].addr; m_din = m_q[0].data; m_wea = m_q[0].wea;
        void'(m_q.pop_front());
        m_wait = 0;
      end else begin
        m_wea = 4'b0;
        m_wait = 0;
      end
      if (m_cpu_acc && cw != 4'b0) m_q.push_back('{ca, cd, cw});
    end
    @(posedge clk);
    #1;
    check("imem_wea", imem_wea, m_wea);
    check("imem_addr", imem_addr, m_addr);
    check("imem_din", imem_din, m_din);
    log_addr.push_back(imem_addr);
    log_data.push_back(imem_din);
    log_wea.push_back(imem_wea);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, '0, '0, 4'h0);
  endtask

  initial begin
    int k;
    int sent;
    logic [AW-1:0] cpu_seen[$];

    m_wait = 0; m_addr = '0; m_din = '0; m_wea = '0; m_cpu_acc = 1'b0;
    rst = 1'b1; cpu_valid = 1'b1; ldr_valid = 1'b1;
    cpu_addr = 14'h5; cpu_data = 32'h55; cpu_wea = 4'hF;
    ldr_addr = 14'h2005; ldr_data = 32'h66; ldr_wea = 4'hF;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 14'h5, 32'h55, 4'hF, 1'b1, 14'h2005, 32'h66, 4'hF);
    check("rst_imem_wea", imem_wea, 4'h0);
    check("rst_drained", drained, 1'b1);
    check("rst_pending", pending, 3'd0);

    // CPU-only back-to-back stores
    clear_log();
    step(1'b0, 1'b1, 14'h10, 32'hA, 4'hF, 1'b0, '0, '0, 4'h0);
    step(1'b0, 1'b1, 14'h11, 32'hB, 4'hF, 1'b0, '0, '0, 4'h0);
    step(1'b0, 1'b1, 14'h12, 32'hC, 4'hF, 1'b0, '0, '0, 4'h0);
    idle(3);
    check("cpu_only_gap", log_wea[0], 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("cpu_only_addr", log_addr[i+1], 64'h10 + i);
      check("cpu_only_data", log_data[i+1], 64'hA + i);
      check("cpu_only_wea", log_wea[i+1], 4'hF);
    end
    check("cpu_only_drained", drained, 1'b1);

    // Zero-mask store is consumed without a write
    clear_log();
    step(1'b0, 1'b1, 14'h33, 32'h33, 4'h0, 1'b0, '0, '0, 4'h0);
    check("zero_mask_acc", m_cpu_acc, 1'b1);
    check("zero_mask_pending", pending, 3'd0);
    idle(2);
    check("zero_mask_nowrite", {log_wea[0], log_wea[1], log_wea[2]}, 12'h0);

    // Starvation: one queued store against a saturating loader
    step(1'b0, 1'b1, 14'h30, 32'h300, 4'hF, 1'b0, '0, '0, 4'h0);
    clear_log();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 14'h2000 + AW'(i), 32'h1000 + i, 4'hF);
    k = 0;
    while (k < log_wea.size() && log_wea[k] != 4'h0 && log_addr[k][13]) k++;
    check("starve_ldr_run", k, LIMIT);
    check("starve_cpu_addr", log_addr[LIMIT], 14'h30);
    check("starve_resume", log_addr[LIMIT+1][13] && log_wea[LIMIT+1] != 4'h0, 1'b1);
    idle(2);

    // Fill the FIFO while the loader is continuously valid
    clear_log();
    sent = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, sent < 5, 14'h20 + AW'(sent), 32'h200 + sent, 4'hF, 1'b1, 14'h2100 + AW'(i), 32'h2100 + i, 4'h3);
      if (m_cpu_acc) sent++;
    end
    idle(6);
    check("full_all_sent", sent, 5);
    foreach (log_addr[i]) if (log_wea[i] != 4'h0 && !log_addr[i][13]) cpu_seen.push_back(log_addr[i]);
    check("full_cpu_count", cpu_seen.size(), 5);
    for (int i = 0; i < cpu_seen.size() && i < 5; i++) check("full_cpu_order", cpu_seen[i], 64'h20 + i);

    // Push and pop together at pending 2, wrapping the pointers
    step(1'b0, 1'b1, 14'h40, 32'h400, 4'hF, 1'b1, 14'h2200, 32'h1, 4'hF);
    step(1'b0, 1'b1, 14'h41, 32'h401, 4'hF, 1'b1, 14'h2201, 32'h2, 4'hF);
    for (int i = 2; i < 9; i++) step(1'b0, 1'b1, 14'h40 + AW'(i), 32'h400 + i, 4'hF, 1'b0, '0, '0, 4'h0);
    check("pushpop_pending", pending, 3'd2);
    idle(4);

    // Randomized traffic with occasional mid-operation resets
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] cw;
      cw = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, AW'($urandom), $urandom, cw,
           $urandom_range(0, 3) != 0, AW'($urandom), $urandom, 4'($urandom));
    end
    idle(12);
    check("final_drained", drained, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
